// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (signed/unsigned), result {rem, quo}.
// Optional DIV_ZERO_FAST_EN: divide-by-zero finishes in one cycle.
module div_unit #(
  parameter logic [4:0] DIV_CONTROL  = 5'b10000,
  parameter logic [4:0] DIVU_CONTROL = 5'b10001
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  alucontrol,
  input  logic        start,
  input  logic        annul,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        ready,
  output logic [63:0] result
);

`ifdef DIV_ZERO_FAST_EN
  localparam logic FAST_ZERO = 1'b1;
`else
  localparam logic FAST_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, nstate;
  logic [5:0]  cnt;
  logic [31:0] a_q, d_q, q_q, r_q;
  logic        bz_q, negq_q, negr_q;
  logic [63:0] res_q;

  logic        sgn, is_div, acc;
  logic [31:0] a_mag, b_mag;
  logic [32:0] trial;
  logic        fit;
  logic [31:0] rsub, qfix, rfix;
  logic [63:0] fin;

  assign sgn    = (alucontrol == DIV_CONTROL);
  assign is_div = sgn || (alucontrol == DIVU_CONTROL);
  assign acc    = (state == IDLE) && start
                  && !annul && is_div;

  assign a_mag = (sgn && a[31]) ? 32'd0 - a : a;
  assign b_mag = (sgn && b[31]) ? 32'd0 - b : b;

  // One restoring step: shift in next dividend bit, subtract if it fits
  assign trial = {r_q, q_q[31]};
  assign fit   = trial >= {1'b0, d_q};
  assign rsub  = trial[31:0] - d_q;

  assign qfix = negq_q ? 32'd0 - q_q : q_q;
  assign rfix = negr_q ? 32'd0 - r_q : r_q;
  assign fin  = bz_q ? {a_q, 32'hFFFF_FFFF}
                     : {rfix, qfix};

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:
        if (acc)
          nstate = (FAST_ZERO && b == 32'd0)
                   ? DONE : RUN;
      RUN:
        if (annul)             nstate = IDLE;
        else if (cnt == 6'd31) nstate = DONE;
      DONE:
        nstate = IDLE;
      default:
        nstate = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign ready  = (state == DONE) && !annul;
  assign result = ready ? fin : res_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      a_q    <= 32'd0;
      d_q    <= 32'd0;
      q_q    <= 32'd0;
      r_q    <= 32'd0;
      bz_q   <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      res_q  <= 64'd0;
    end else begin
      state <= nstate;
      if (acc) begin
        a_q    <= a;
        d_q    <= b_mag;
        q_q    <= a_mag;
        r_q    <= 32'd0;
        cnt    <= 6'd0;
        bz_q   <= (b == 32'd0);
        negq_q <= sgn && (a[31] ^ b[31]);
        negr_q <= sgn && a[31];
      end else if (state == RUN) begin
        q_q <= {q_q[30:0], fit};
        r_q <= fit ? rsub : trial[31:0];
        cnt <= cnt + 6'd1;
      end
      if (ready)
        res_q <= fin;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors, monitor checks
// result value and ready cycle against queued expectations.
module tb_div_unit;

  localparam logic [4:0] DIV  = 5'b10000;
  localparam logic [4:0] DIVU = 5'b10001;
  localparam logic [4:0] ADD  = 5'b00010;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic        clk, resetn, start, annul;
  logic [4:0]  alucontrol;
  logic [31:0] a, b;
  logic        busy, ready;
  logic [63:0] result;

  div_unit dut (
    .clk(clk), .resetn(resetn),
    .alucontrol(alucontrol),
    .start(start), .annul(annul),
    .a(a), .b(b),
    .busy(busy), .ready(ready),
    .result(result)
  );

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int nready = 0;
  logic [63:0] last_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Monitor: every ready pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (resetn && ready) begin
      nready++;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ready: got result %h at cycle %0d want none",
                 result, cyc);
      end else begin
        e = sb.pop_front();
        if (result !== e.res) begin
          n_fail++;
          $display("FAIL result: got %h want %h", result, e.res);
        end
        n_chk++;
        if (cyc != e.cyc) begin
          n_fail++;
          $display("FAIL ready_cycle: got %0d want %0d", cyc, e.cyc);
        end
      end
    end
  end

  // Called at a negedge; leaves caller at the negedge of cycle N+1
  task automatic issue(input logic [4:0] ctl,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input logic [63:0] want,
                       input int lat,
                       input bit push);
    exp_t t;
    alucontrol = ctl;
    a = x;
    b = y;
    start = 1'b1;
    if (push) begin
      t.res = want;
      t.cyc = cyc + lat;
      sb.push_back(t);
      last_res = want;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Leaves caller at the negedge of the cycle after ready
  task automatic wait_ready(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no ready want ready", name);
    end else begin
      chk({name, "_busy_done"}, {63'd0, busy}, 64'd1);
      @(negedge clk);
      chk({name, "_busy_after"}, {63'd0, busy}, 64'd0);
      chk({name, "_hold"}, result, last_res);
    end
  endtask

  initial begin
    int n0;
    resetn = 1'b0;
    start = 1'b0;
    annul = 1'b0;
    alucontrol = 5'd0;
    a = 32'd0;
    b = 32'd0;
    last_res = 64'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_result", result, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    chk("idle_busy", {63'd0, busy}, 64'd0);
    issue(DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1);
    chk("run_busy", {63'd0, busy}, 64'd1);
    wait_ready("divu_100_7");

    issue(DIV, 32'hFFFF_FFF9, 32'd2,
          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1);
    wait_ready("div_m7_2");
    issue(DIV, 32'd7, 32'hFFFF_FFFE,
          {32'd1, 32'hFFFF_FFFD}, 33, 1);
    wait_ready("div_7_m2");

    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF,
          {32'd0, 32'h8000_0000}, 33, 1);
    wait_ready("div_ovf");
    issue(DIVU, 32'h8000_0000, 32'hFFFF_FFFF,
          {32'h8000_0000, 32'd0}, 33, 1);
    wait_ready("divu_big");

    issue(DIVU, 32'd5, 32'd0,
          {32'd5, 32'hFFFF_FFFF}, ZLAT, 1);
    wait_ready("divu_zero");
    issue(DIV, 32'hFFFF_FFF8, 32'd0,
          {32'hFFFF_FFF8, 32'hFFFF_FFFF}, ZLAT, 1);
    wait_ready("div_zero");

    issue(DIVU, 32'hFFFF_FFFF, 32'd1,
          {32'd0, 32'hFFFF_FFFF}, 33, 1);
    wait_ready("divu_max_1");
    issue(DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
          {32'hFFFF_FFFE, 32'd14}, 33, 1);
    wait_ready("div_m100_m7");

    // Abort in flight at N+10
    n0 = nready;
    issue(DIVU, 32'd1000, 32'd3, 64'd0, 33, 0);
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_result", result, last_res);
    repeat (40) @(negedge clk);
    chk("abort_noready", 64'(nready - n0), 64'd0);

    // start with annul, and non-divide opcode, are ignored
    start = 1'b1;
    annul = 1'b1;
    alucontrol = DIV;
    a = 32'd9;
    b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    annul = 1'b0;
    chk("annul_start_busy", {63'd0, busy}, 64'd0);
    start = 1'b1;
    alucontrol = ADD;
    @(negedge clk);
    start = 1'b0;
    chk("add_start_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("ignored_noready", 64'(nready - n0), 64'd0);

    // Reset mid-operation at N+20
    issue(DIVU, 32'd77, 32'd5, 64'd0, 33, 0);
    repeat (19) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_ready", {63'd0, ready}, 64'd0);
    chk("midrst_result", result, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    last_res = 64'd0;
    repeat (40) @(negedge clk);
    chk("midrst_noready", 64'(nready - n0), 64'd0);

    issue(DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1);
    wait_ready("post_rst");

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port alucontrol, input, 5 bits: ALU control code from defines.vh; DIV_CONTROL selects signed, DIVU_CONTROL selects unsigned.
REQ-004 SHALL have port start, input, 1 bit: request a division this cycle.
REQ-005 SHALL have port annul, input, 1 bit: abort the operation in flight (flush/exception).
REQ-006 SHALL have port a, input, 32 bits: dividend (rs).
REQ-007 SHALL have port b, input, 32 bits: divisor (rt).
REQ-008 SHALL have port busy, output, 1 bit: division in progress; pipeline stalls while high.
REQ-009 SHALL have port ready, output, 1 bit: one-cycle pulse; result is valid.
REQ-010 SHALL have port result, output, 64 bits: {hi = remainder, lo = quotient}.

Function
REQ-011 SHALL use FSM states IDLE, RUN and DONE.
REQ-012 SHALL accept start only in IDLE, only with annul low, and only with alucontrol equal to DIV_CONTROL or DIVU_CONTROL; otherwise ignore it.
REQ-013 SHALL, on accepted start in cycle N, latch a, b and signedness, then go to RUN.
REQ-014 SHALL perform one restoring radix-2 iteration per cycle in RUN using a 6-bit counter: 32 iterations in cycles N+1..N+32, then DONE.
REQ-015 SHALL assert ready only in DONE (cycle N+33) and then return to IDLE.
REQ-016 SHALL drive busy high in cycles N+1..N+33 inclusive and low in IDLE.
REQ-017 SHALL, for signed operations, divide magnitudes, negate the quotient if the operand signs differ, and give the remainder the sign of the dividend.
REQ-018 SHALL, for signed 0x80000000 / 0xFFFFFFFF, give lo = 0x80000000 and hi = 0 with no trap.
REQ-019 SHALL, when the divisor is 0 (signed or unsigned), give result = {a, 32'hFFFFFFFF}.
REQ-020 SHALL update result only in the DONE cycle and hold it otherwise, including across aborts.
REQ-021 SHALL, when annul is high in RUN or DONE, go to IDLE on the next edge with no ready pulse (ready suppressed in that cycle) and result unchanged.
REQ-022 SHALL ignore start while busy; a new start is accepted in the cycle after ready (back-to-back).

Reset
REQ-023 SHALL, while resetn = 0, immediately force: state IDLE, counter 0, busy 0, ready 0, result 64'h0, internal operand and partial-remainder registers 0.
REQ-024 SHALL, on reset mid-operation, discard the operation; no ready after reset release.

Configuration
REQ-025 SHALL use the macro DIV_ZERO_FAST_EN to select divide-by-zero timing.
REQ-026 SHALL, with DIV_ZERO_FAST_EN defined, on accepted start with b = 0, go straight to DONE: ready in cycle N+1, busy high only in N+1, result per REQ-019.
REQ-027 SHALL, without DIV_ZERO_FAST_EN, take the full 33-cycle latency for b = 0, with the same result value.

Verification
REQ-028 Unsigned: DIVU, a = 100, b = 7, start at N -> ready at N+33 only; result = {32'd2, 32'd14}; busy high N+1..N+33.
REQ-029 Signed: DIV, a = -7 (0xFFFFFFF9), b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; then back-to-back DIV 7 / -2 -> lo = 0xFFFFFFFD, hi = 1.
REQ-030 Overflow: DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0; DIVU, same operands -> lo = 0, hi = 0x80000000.
REQ-031 Divide-by-zero: DIVU 5 / 0 -> result = {32'd5, 32'hFFFFFFFF}; ready at N+1 with DIV_ZERO_FAST_EN, at N+33 without.
REQ-032 Abort: annul at N+10 -> busy low at N+11, no ready, result keeps its prior value; start with annul together -> ignored; start with alucontrol = ADD_CONTROL -> ignored.
REQ-033 Reset: resetn low at N+20 -> busy, ready and result go to 0 immediately; no ready within 40 cycles after release.
